// File: rtl/seg_decode_mon.sv
// seg_decode_mon: samples a multiplexed active-low 7-segment bus and decodes each digit back to BCD.
// Optional macro SEG_HEX_EN additionally accepts the A-F glyphs as valid digits.
module seg_decode_mon #(
  parameter int NUM_DIG    = 4,
  parameter int STABLE_CYC = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [6:0]           seg_hex,
  input  logic [NUM_DIG-1:0]   dig_sel,
  input  logic                 err_clr,
  output logic [4*NUM_DIG-1:0] dig_val,
  output logic [NUM_DIG-1:0]   dig_vld,
  output logic                 upd_pulse,
  output logic [2:0]           upd_idx,
  output logic                 err_sticky
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {WAIT, SETTLE, HOLD} state_t;
  typedef enum logic [1:0] {PAT_DIG, PAT_BLANK, PAT_INV} pat_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        stab_cnt_q, stab_cnt_d;
  logic [6:0]           s_seg_q, s_seg_d, p_seg_q, p_seg_d;
  logic [NUM_DIG-1:0]   s_sel_q, s_sel_d, p_sel_q, p_sel_d;
  logic [4*NUM_DIG-1:0] val_q, val_d;
  logic [NUM_DIG-1:0]   vld_q, vld_d;
  logic                 pulse_q, pulse_d;
  logic [2:0]           idx_q, idx_d;
  logic                 err_q, err_d;

  logic       sel_onehot, changed, try_cap;
  logic [2:0] sel_idx;
  pat_t       dec_kind;
  logic [3:0] dec_val;

  assign sel_onehot = (s_sel_q != '0) && ((s_sel_q & (s_sel_q - NUM_DIG'(1))) == '0);
  assign changed    = {s_sel_q, s_seg_q} != {p_sel_q, p_seg_q};

  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (s_sel_q[i]) sel_idx = 3'(i);
    end
  end

  always_comb begin
    dec_kind = PAT_DIG;
    dec_val  = 4'd0;
    case (s_seg_q)
      7'h40: dec_val = 4'd0;
      7'h79: dec_val = 4'd1;
      7'h24: dec_val = 4'd2;
      7'h30: dec_val = 4'd3;
      7'h19: dec_val = 4'd4;
      7'h12: dec_val = 4'd5;
      7'h02: dec_val = 4'd6;
      7'h78: dec_val = 4'd7;
      7'h00: dec_val = 4'd8;
      7'h10: dec_val = 4'd9;
`ifdef SEG_HEX_EN
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
`endif
      7'h7F: dec_kind = PAT_BLANK;
      default: dec_kind = PAT_INV;
    endcase
  end

  always_comb begin
    s_seg_d    = seg_hex;
    s_sel_d    = dig_sel;
    p_seg_d    = s_seg_q;
    p_sel_d    = s_sel_q;
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    val_d      = val_q;
    vld_d      = vld_q;
    pulse_d    = 1'b0;
    idx_d      = idx_q;
    err_d      = err_q & ~err_clr;
    try_cap    = 1'b0;

    case (state_q)
      WAIT: begin
        if (sel_onehot) begin
          state_d    = SETTLE;
          stab_cnt_d = CNT_ONE;
          try_cap    = 1'b1;
        end
      end
      SETTLE: begin
        if (!sel_onehot) begin
          state_d    = WAIT;
          stab_cnt_d = '0;
        end else begin
          try_cap = 1'b1;
          if (changed) stab_cnt_d = CNT_ONE;
          else if (stab_cnt_q < CNT_MAX) stab_cnt_d = stab_cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (!sel_onehot) begin
          state_d    = WAIT;
          stab_cnt_d = '0;
        end else if (changed) begin
          state_d    = SETTLE;
          stab_cnt_d = CNT_ONE;
          try_cap    = 1'b1;
        end
      end
      default: begin
        state_d    = WAIT;
        stab_cnt_d = '0;
      end
    endcase

    // A fresh one-hot sample with STABLE_CYC=1 captures straight away, skipping SETTLE.
    if (try_cap && stab_cnt_d == CNT_MAX) begin
      state_d = HOLD;
      pulse_d = 1'b1;
      idx_d   = sel_idx;
      for (int i = 0; i < NUM_DIG; i++) begin
        if (s_sel_q[i]) begin
          case (dec_kind)
            PAT_DIG: begin
              val_d[4*i +: 4] = dec_val;
              vld_d[i]        = 1'b1;
            end
            PAT_BLANK: begin
              val_d[4*i +: 4] = 4'd0;
              vld_d[i]        = 1'b0;
            end
            default: begin
              vld_d[i] = 1'b0;
              err_d    = 1'b1;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= WAIT;
      stab_cnt_q <= '0;
      s_seg_q    <= '0;
      s_sel_q    <= '0;
      p_seg_q    <= '0;
      p_sel_q    <= '0;
      val_q      <= '0;
      vld_q      <= '0;
      pulse_q    <= 1'b0;
      idx_q      <= 3'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      s_seg_q    <= s_seg_d;
      s_sel_q    <= s_sel_d;
      p_seg_q    <= p_seg_d;
      p_sel_q    <= p_sel_d;
      val_q      <= val_d;
      vld_q      <= vld_d;
      pulse_q    <= pulse_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
    end
  end

  assign dig_val    = val_q;
  assign dig_vld    = vld_q;
  assign upd_pulse  = pulse_q;
  assign upd_idx    = idx_q;
  assign err_sticky = err_q;
endmodule

// File: tb/tb_seg_decode_mon.sv
// Self-checking bench for seg_decode_mon: directed scenarios plus randomized runs against a run-length model.
module tb_seg_decode_mon;
  localparam int NUM_DIG = 4;
  localparam int S       = 16;

  logic                 sys_clk = 1'b0;
  logic                 rst;
  logic [6:0]           seg_hex;
  logic [NUM_DIG-1:0]   dig_sel;
  logic                 err_clr;
  logic [4*NUM_DIG-1:0] dig_val;
  logic [NUM_DIG-1:0]   dig_vld;
  logic                 upd_pulse;
  logic [2:0]           upd_idx;
  logic                 err_sticky;

  always #5 sys_clk = ~sys_clk;

  seg_decode_mon #(.NUM_DIG(NUM_DIG), .STABLE_CYC(S)) dut (
    .sys_clk(sys_clk), .rst(rst), .seg_hex(seg_hex), .dig_sel(dig_sel), .err_clr(err_clr),
    .dig_val(dig_val), .dig_vld(dig_vld), .upd_pulse(upd_pulse), .upd_idx(upd_idx),
    .err_sticky(err_sticky)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: lut gives digit value, -1 for blank, -2 for invalid.
  int lut[128];
  logic [6:0] pats[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int                 m_val[NUM_DIG];
  logic [NUM_DIG-1:0] m_vld;
  logic               m_err, m_pulse;
  int                 m_idx;
  int                 run_len;
  logic [3:0]         run_sel;
  logic [6:0]         run_seg;
  int                 cyc, pulse_cnt, last_idx, pulse_at;

  function automatic logic [15:0] exp_val();
    logic [15:0] v;
    for (int i = 0; i < NUM_DIG; i++) v[4*i +: 4] = 4'(m_val[i]);
    return v;
  endfunction

  // One clock: drive inputs, advance the model for that edge, settle 1 time unit past the edge.
  task automatic step(input logic [3:0] sel, input logic [6:0] seg, input logic clr, input logic r);
    int code;
    code = 0;
    dig_sel = sel; seg_hex = seg; err_clr = clr; rst = r;
    @(posedge sys_clk);
    if (r) begin
      for (int i = 0; i < NUM_DIG; i++) m_val[i] = 0;
      m_vld = '0; m_err = 1'b0; m_pulse = 1'b0; m_idx = 0; run_len = 0;
    end else begin
      // A run of exactly S identical one-hot samples captures once, one edge later.
      m_pulse = (run_len == S) && ($countones(run_sel) == 1);
      if (m_pulse) begin
        m_idx = $clog2(run_sel);
        code  = lut[run_seg];
        if (code >= 0) begin
          m_val[m_idx] = code; m_vld[m_idx] = 1'b1;
        end else begin
          m_vld[m_idx] = 1'b0;
          if (code == -1) m_val[m_idx] = 0;
        end
      end
      m_err = (m_err && !clr) || (m_pulse && code == -2);
      if (run_len > 0 && sel == run_sel && seg == run_seg) begin
        if (run_len < 1000) run_len++;
      end else begin
        run_len = 1; run_sel = sel; run_seg = seg;
      end
    end
    #1;
    if (upd_pulse === 1'b1) begin
      pulse_cnt++; last_idx = int'(upd_idx); pulse_at = cyc;
    end
    cyc++;
  endtask

  task automatic test_reset();
    step(4'b0101, 7'h24, 1'b1, 1'b1);
    step(4'b0000, 7'h7F, 1'b0, 1'b1);
    n_checks++; if (dig_val !== 16'h0) begin n_fail++; $display("FAIL reset dig_val got %h exp 0000", dig_val); end
    n_checks++; if (dig_vld !== 4'h0) begin n_fail++; $display("FAIL reset dig_vld got %b exp 0000", dig_vld); end
    n_checks++; if (upd_pulse !== 1'b0) begin n_fail++; $display("FAIL reset upd_pulse got %b exp 0", upd_pulse); end
    n_checks++; if (upd_idx !== 3'd0) begin n_fail++; $display("FAIL reset upd_idx got %0d exp 0", upd_idx); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset err_sticky got %b exp 0", err_sticky); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int start;
    pulse_cnt = 0; start = cyc;
    for (int i = 0; i < 20; i++) begin
      step(4'b0001, 7'h24, 1'b0, 1'b0);
      n_checks++; if (upd_pulse !== m_pulse) begin n_fail++; $display("FAIL single pulse cyc %0d got %b exp %b", i, upd_pulse, m_pulse); end
    end
    n_checks++; if (pulse_cnt != 1) begin n_fail++; $display("FAIL single pulse_count got %0d exp 1", pulse_cnt); end
    n_checks++; if (pulse_at - start != S) begin n_fail++; $display("FAIL single latency got %0d exp %0d", pulse_at - start, S); end
    n_checks++; if (last_idx != 0) begin n_fail++; $display("FAIL single upd_idx got %0d exp 0", last_idx); end
    n_checks++; if (dig_val[3:0] !== 4'd2) begin n_fail++; $display("FAIL single dig0 got %h exp 2", dig_val[3:0]); end
    n_checks++; if (dig_vld !== 4'b0001) begin n_fail++; $display("FAIL single dig_vld got %b exp 0001", dig_vld); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL single err_sticky got %b exp 0", err_sticky); end
    $display("test_single: pulses=%0d dig_val=%h", pulse_cnt, dig_val);
  endtask

  task automatic test_scan();
    logic [6:0] sp[4] = '{7'h10, 7'h19, 7'h78, 7'h40};
    pulse_cnt = 0;
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 20; i++) begin
        step(4'(1 << d), sp[d], 1'b0, 1'b0);
        n_checks++; if (upd_pulse !== m_pulse) begin n_fail++; $display("FAIL scan pulse dig %0d cyc %0d got %b exp %b", d, i, upd_pulse, m_pulse); end
      end
    end
    step(4'b0000, 7'h7F, 1'b0, 1'b0);
    n_checks++; if (pulse_cnt != 4) begin n_fail++; $display("FAIL scan pulse_count got %0d exp 4", pulse_cnt); end
    n_checks++; if (dig_val !== 16'h0749) begin n_fail++; $display("FAIL scan dig_val got %h exp 0749", dig_val); end
    n_checks++; if (dig_vld !== 4'hF) begin n_fail++; $display("FAIL scan dig_vld got %b exp 1111", dig_vld); end
    $display("test_scan: pulses=%0d dig_val=%h", pulse_cnt, dig_val);
  endtask

  task automatic test_toggle();
    pulse_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step(4'b0010, ((i / 10) % 2 == 0) ? 7'h40 : 7'h79, 1'b0, 1'b0);
      n_checks++; if (upd_pulse !== m_pulse) begin n_fail++; $display("FAIL toggle pulse cyc %0d got %b exp %b", i, upd_pulse, m_pulse); end
    end
    n_checks++; if (pulse_cnt != 0) begin n_fail++; $display("FAIL toggle no_capture got %0d pulses exp 0", pulse_cnt); end
    for (int i = 0; i < 20; i++) step(4'b0010, 7'h24, 1'b0, 1'b0);
    n_checks++; if (pulse_cnt != 1) begin n_fail++; $display("FAIL toggle hold_capture got %0d pulses exp 1", pulse_cnt); end
    n_checks++; if (dig_val[7:4] !== 4'd2) begin n_fail++; $display("FAIL toggle dig1 got %h exp 2", dig_val[7:4]); end
    $display("test_toggle: pulses=%0d dig_val=%h", pulse_cnt, dig_val);
  endtask

  task automatic test_invalid();
    for (int i = 0; i < 20; i++) step(4'b0100, 7'h55, 1'b0, 1'b0);
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL invalid err_sticky got %b exp 1", err_sticky); end
    n_checks++; if (dig_vld[2] !== 1'b0) begin n_fail++; $display("FAIL invalid dig_vld2 got %b exp 0", dig_vld[2]); end
    n_checks++; if (dig_val[11:8] !== 4'd7) begin n_fail++; $display("FAIL invalid dig2_kept got %h exp 7", dig_val[11:8]); end
    n_checks++; if (dig_val !== exp_val()) begin n_fail++; $display("FAIL invalid dig_val got %h exp %h", dig_val, exp_val()); end
    step(4'b0100, 7'h55, 1'b1, 1'b0);
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL invalid err_clr got %b exp 0", err_sticky); end
    $display("test_invalid: err after clear=%b", err_sticky);
  endtask

  task automatic test_wait();
    logic [3:0] bad[2] = '{4'b0011, 4'b0000};
    pulse_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 40; i++) begin
        step(bad[k], 7'h30, 1'b0, 1'b0);
        n_checks++; if (upd_pulse !== m_pulse) begin n_fail++; $display("FAIL wait pulse sel %b cyc %0d got %b exp %b", bad[k], i, upd_pulse, m_pulse); end
      end
    end
    n_checks++; if (pulse_cnt != 0) begin n_fail++; $display("FAIL wait no_capture got %0d pulses exp 0", pulse_cnt); end
    n_checks++; if (dig_val !== exp_val()) begin n_fail++; $display("FAIL wait dig_val got %h exp %h", dig_val, exp_val()); end
    $display("test_wait: pulses=%0d", pulse_cnt);
  endtask

  task automatic test_hex();
    for (int i = 0; i < 20; i++) step(4'b0010, 7'h08, 1'b0, 1'b0);
`ifdef SEG_HEX_EN
    n_checks++; if (dig_val[7:4] !== 4'hA) begin n_fail++; $display("FAIL hex dig1 got %h exp A", dig_val[7:4]); end
    n_checks++; if (dig_vld[1] !== 1'b1) begin n_fail++; $display("FAIL hex dig_vld1 got %b exp 1", dig_vld[1]); end
`else
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL hex err_sticky got %b exp 1", err_sticky); end
    n_checks++; if (dig_vld[1] !== 1'b0) begin n_fail++; $display("FAIL hex dig_vld1 got %b exp 0", dig_vld[1]); end
`endif
    $display("test_hex: dig_val=%h dig_vld=%b err=%b", dig_val, dig_vld, err_sticky);
  endtask

  task automatic test_set_wins();
    step(4'b0000, 7'h7F, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(4'b0001, 7'h55, (i == S) ? 1'b1 : 1'b0, 1'b0);
      n_checks++; if (err_sticky !== m_err) begin n_fail++; $display("FAIL set_wins err cyc %0d got %b exp %b", i, err_sticky, m_err); end
    end
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL set_wins final err got %b exp 1", err_sticky); end
    $display("test_set_wins: err=%b", err_sticky);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) step(4'b1000, 7'h12, 1'b0, 1'b0);
    step(4'b1000, 7'h12, 1'b0, 1'b1);
    n_checks++; if (dig_val !== 16'h0 || dig_vld !== 4'h0 || err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid state got %h/%b/%b exp 0000/0000/0", dig_val, dig_vld, err_sticky);
    end
    pulse_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b1000, 7'h12, 1'b0, 1'b0);
      n_checks++; if (upd_pulse !== m_pulse) begin n_fail++; $display("FAIL reset_mid pulse cyc %0d got %b exp %b", i, upd_pulse, m_pulse); end
    end
    n_checks++; if (dig_val[15:12] !== 4'd5) begin n_fail++; $display("FAIL reset_mid dig3 got %h exp 5", dig_val[15:12]); end
    $display("test_reset_mid: pulses=%0d dig_val=%h", pulse_cnt, dig_val);
  endtask

  task automatic test_random();
    logic [3:0] multi[5] = '{4'b0011, 4'b0101, 4'b0110, 4'b1100, 4'b1111};
    logic [3:0] sel;
    logic [6:0] seg;
    int r, len;
    pulse_cnt = 0;
    for (int run = 0; run < 80; run++) begin
      r = $urandom_range(0, 9);
      if (r < 7) sel = 4'(1 << $urandom_range(0, 3));
      else if (r == 7) sel = 4'b0000;
      else sel = multi[$urandom_range(0, 4)];
      r = $urandom_range(0, 9);
      if (r < 5) seg = pats[$urandom_range(0, 9)];
      else if (r == 5) seg = 7'h7F;
      else seg = 7'($urandom_range(0, 127));
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        step(sel, seg, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, 1'b0);
        n_checks++; if (upd_pulse !== m_pulse) begin n_fail++; $display("FAIL random pulse run %0d got %b exp %b", run, upd_pulse, m_pulse); end
        if (m_pulse) begin
          n_checks++; if (int'(upd_idx) != m_idx) begin n_fail++; $display("FAIL random upd_idx run %0d got %0d exp %0d", run, upd_idx, m_idx); end
        end
        n_checks++; if (dig_val !== exp_val()) begin n_fail++; $display("FAIL random dig_val run %0d got %h exp %h", run, dig_val, exp_val()); end
        n_checks++; if (dig_vld !== m_vld) begin n_fail++; $display("FAIL random dig_vld run %0d got %b exp %b", run, dig_vld, m_vld); end
        n_checks++; if (err_sticky !== m_err) begin n_fail++; $display("FAIL random err_sticky run %0d got %b exp %b", run, err_sticky, m_err); end
      end
    end
    $display("test_random: pulses=%0d", pulse_cnt);
  endtask

  initial begin
    cyc = 0; pulse_cnt = 0; last_idx = 0; pulse_at = 0;
    run_len = 0; run_sel = '0; run_seg = '0;
    m_vld = '0; m_err = 1'b0; m_pulse = 1'b0; m_idx = 0;
    for (int i = 0; i < NUM_DIG; i++) m_val[i] = 0;
    for (int i = 0; i < 128; i++) lut[i] = -2;
    for (int i = 0; i < 10; i++) lut[pats[i]] = i;
    lut[7'h7F] = -1;
`ifdef SEG_HEX_EN
    lut[7'h08] = 10; lut[7'h03] = 11; lut[7'h46] = 12;
    lut[7'h21] = 13; lut[7'h06] = 14; lut[7'h0E] = 15;
`endif
    rst = 1'b1; dig_sel = '0; seg_hex = 7'h7F; err_clr = 1'b0;
    test_reset();
    test_single();
    test_scan();
    test_toggle();
    test_invalid();
    test_wait();
    test_hex();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_decode_mon.md
Name: seg_decode_mon

Overview:
- Display-side monitor: samples the multiplexed active-low 7-segment bus and the digit-select lines, and decodes patterns back to BCD.
- Holds one decoded value per digit, flags unknown patterns, and pulses on every digit update.
- Used for on-board loopback checking of the segment drivers and as a self-check in the display subsystem.

Parameters:
- NUM_DIG, 4, number of multiplexed digits (1..8).
- STABLE_CYC, 16, consecutive identical samples of {dig_sel, seg_hex} required before capture (>=1).

Ports:
- sys_clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- seg_hex  in  7  segment pattern, active-low; bit0=a .. bit6=g.
- dig_sel  in  NUM_DIG  digit enable, active-high; must be one-hot to be valid.
- err_clr  in  1  clears err_sticky (single-cycle strobe).
- dig_val  out  4*NUM_DIG  decoded value; digit i in bits [4i+3:4i].
- dig_vld  out  NUM_DIG  digit i holds a decoded value (not blank, not invalid).
- upd_pulse  out  1  one-cycle strobe when any digit is captured.
- upd_idx  out  3  index of the digit captured; valid with upd_pulse.
- err_sticky  out  1  an invalid pattern was captured since the last clear.

Behaviour:
- Inputs registered once (s_seg, s_sel) before use; this input stage is counted in latency.
- Reset (rst=1 at a clock edge): dig_val=0, dig_vld=0, upd_pulse=0, upd_idx=0, err_sticky=0, stab_cnt=0, state=WAIT.
- Decode table: 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9.
  - 0x7F is blank.
  - Any other pattern is invalid.
- FSM:
  - WAIT: s_sel not one-hot (zero or multiple bits). Stay here, stab_cnt=0. When s_sel becomes one-hot, go to SETTLE with stab_cnt=1.
  - SETTLE: if {s_sel, s_seg} equals the previous sample, stab_cnt increments. On any change, stab_cnt=1 (still SETTLE), or go to WAIT if s_sel is no longer one-hot. When stab_cnt reaches STABLE_CYC, capture and go to HOLD.
  - HOLD: stay while the sample is unchanged; no repeat capture. On change, go to SETTLE (stab_cnt=1) or WAIT, using the same rule as SETTLE.
- Capture (single cycle, on the SETTLE->HOLD transition), with i = index of the set s_sel bit:
  - Decimal pattern: dig_val[i] = value, dig_vld[i]=1.
  - Blank: dig_val[i]=0, dig_vld[i]=0.
  - Invalid: dig_val[i] unchanged, dig_vld[i]=0, err_sticky=1.
  - In all cases upd_pulse=1 and upd_idx=i for exactly this cycle.
- Latency: a stable input applied at edge k produces upd_pulse after edge k+STABLE_CYC (one register stage plus STABLE_CYC-1 compare cycles).
- STABLE_CYC=1: capture on the first registered one-hot sample.
- stab_cnt saturates at STABLE_CYC; it never wraps.
- err_clr and an invalid capture in the same cycle: set wins, err_sticky=1.
- Other digits' dig_val and dig_vld are never touched by a capture.
- rst asserted mid-SETTLE: everything returns to reset values at that edge; any partial stability count is discarded.

Optional Feature:
- SEG_HEX_EN.
  - Defined: additionally decodes A-F as valid: 0x08->A, 0x03->b, 0x46->C, 0x21->d, 0x06->E, 0x0E->F. Values are 0xA-0xF with dig_vld=1.
  - Undefined: these six patterns are invalid and set err_sticky.

Test Plan:
- Reset, then dig_sel=4'b0001, seg_hex=0x24 held 16 cycles -> one upd_pulse, upd_idx=0, dig_val[3:0]=2, dig_vld=4'b0001, err_sticky=0.
- Scan digits 0..3 with 9,4,7,0, each held 20 cycles -> dig_val=0x0749, dig_vld=4'hF, exactly 4 pulses.
- dig_sel=4'b0010, seg_hex toggles 0x40/0x79 every 10 cycles -> no upd_pulse; a 16-cycle hold then captures.
- dig_sel=4'b0100, seg_hex=0x55 held 16 cycles -> err_sticky=1, dig_vld[2]=0, dig_val[11:8] unchanged; err_clr pulse -> err_sticky=0.
- dig_sel=4'b0011 or 4'b0000 with a valid pattern for 40 cycles -> no capture, stays in WAIT.
- seg_hex=0x08 on digit 1 for 16 cycles -> with SEG_HEX_EN: dig_val[7:4]=0xA, dig_vld[1]=1; without: err_sticky=1.
